// File: rtl/timer_multi_ip.sv
// rtl/timer_multi_ip.sv - NUM_CH independent down-counting timers behind one register slave port
// Each channel: prescaler, one-shot/periodic reload, sticky W1C TIMEOUT/OVERRUN, maskable IRQ.
module timer_multi_ip #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [31:0] ch_num;
  logic [3:0]  offset;
  logic [31:0] rd_word [NUM_CH];
  logic        unused_wdata;

  assign ch_num       = 32'(addr[ADDR_W-1:4]);
  assign offset       = addr[3:0];
  assign unused_wdata = ^wdata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic               en, mode, presc_en, irq_en, en_q, timeout, overrun;
    logic [PRESC_W-1:0] div, presc_cnt;
    logic [CNT_W-1:0]   load, value;
    logic               hit, start, tick, expire;

    assign hit    = sel && we && (ch_num == 32'(i));
    // The cycle after EN rises is spent reloading, so it never counts.
    assign start  = en && !en_q;
    assign tick   = en && !start && (!presc_en || presc_cnt == div);
    assign expire = tick && (value <= CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        en        <= 1'b0;
        mode      <= 1'b0;
        presc_en  <= 1'b0;
        irq_en    <= 1'b0;
        en_q      <= 1'b0;
        timeout   <= 1'b0;
        overrun   <= 1'b0;
        div       <= '0;
        presc_cnt <= '0;
        load      <= '0;
        value     <= '0;
      end else begin
        en_q <= en;
        if (hit && offset == 4'h0) begin
          en       <= wdata[0];
          mode     <= wdata[1];
          presc_en <= wdata[2];
          irq_en   <= wdata[3];
          div      <= wdata[8 +: PRESC_W];
        end else if (expire && !mode) begin
          en <= 1'b0;
        end

        if (hit && offset == 4'h4) load <= wdata[CNT_W-1:0];

        if (hit && offset == 4'h8) value <= wdata[CNT_W-1:0];
        else if (start)            value <= load;
        else if (expire)           value <= mode ? load : '0;
        else if (tick)             value <= value - CNT_W'(1);

        if (!en || !presc_en || start || presc_cnt == div) presc_cnt <= '0;
        else                                               presc_cnt <= presc_cnt + PRESC_W'(1);

        // Hardware set wins over a same-cycle W1C so an event is never dropped.
        if (expire)                                   timeout <= 1'b1;
        else if (hit && offset == 4'hC && wdata[0])   timeout <= 1'b0;
        if (expire && timeout)                        overrun <= 1'b1;
        else if (hit && offset == 4'hC && wdata[1])   overrun <= 1'b0;
      end
    end

    assign irq[i] = timeout && irq_en;

    assign rd_word[i] = (offset == 4'h0) ? 32'({div, 4'b0000, irq_en, presc_en, mode, en})
                      : (offset == 4'h4) ? 32'(load)
                      : (offset == 4'h8) ? 32'(value)
                      : (offset == 4'hC) ? {30'd0, overrun, timeout}
                      : 32'd0;
  end

  assign irq_any = |irq;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_num == 32'(c)) rdata = rd_word[c];
  end

endmodule

// File: tb/tb_timer_multi_ip.sv
// tb/tb_timer_multi_ip.sv - directed and randomized checks of timer_multi_ip against a behavioural model
module tb_timer_multi_ip;
  localparam int NCH = 4;
  localparam int AW  = 8;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           sel = 1'b0;
  logic           we = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic [NCH-1:0] irq;
  logic           irq_any;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  timer_multi_ip #(.NUM_CH(NCH), .CNT_W(32), .PRESC_W(8), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one record per channel, advanced once per clock by the spec rules.
  bit          m_en[NCH], m_mode[NCH], m_pen[NCH], m_ie[NCH], m_was_on[NCH], m_to[NCH], m_ov[NCH];
  int unsigned m_div[NCH], m_ph[NCH], m_load[NCH], m_val[NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_pen[c] = 0; m_ie[c] = 0; m_was_on[c] = 0;
      m_to[c] = 0; m_ov[c] = 0; m_div[c] = 0; m_ph[c] = 0; m_load[c] = 0; m_val[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit s, input bit w, input logic [7:0] a, input logic [31:0] d);
    bit          wr, starting, ticks, fires, nen, nto, nov;
    int unsigned nval, nph;
    for (int c = 0; c < NCH; c++) begin
      wr       = s && w && (int'(a[7:4]) == c);
      starting = m_en[c] && !m_was_on[c];
      ticks    = m_en[c] && !starting && (!m_pen[c] || m_ph[c] == m_div[c]);
      fires    = ticks && (m_val[c] <= 1);
      if (starting)   nval = m_load[c];
      else if (fires) nval = m_mode[c] ? m_load[c] : 0;
      else if (ticks) nval = m_val[c] - 1;
      else            nval = m_val[c];
      nen = (fires && !m_mode[c]) ? 1'b0 : m_en[c];
      nph = (m_en[c] && m_pen[c] && !starting && m_ph[c] != m_div[c]) ? m_ph[c] + 1 : 0;
      nto = m_to[c];
      nov = m_ov[c];
      if (wr && a[3:0] == 4'hC) begin
        if (d[0]) nto = 0;
        if (d[1]) nov = 0;
      end
      if (fires) begin
        if (m_to[c]) nov = 1;
        nto = 1;
      end
      m_was_on[c] = m_en[c];
      if (wr && a[3:0] == 4'h0) begin
        nen = d[0]; m_mode[c] = d[1]; m_pen[c] = d[2]; m_ie[c] = d[3]; m_div[c] = d[15:8];
      end
      if (wr && a[3:0] == 4'h4) m_load[c] = d;
      if (wr && a[3:0] == 4'h8) nval = d;
      m_en[c] = nen; m_val[c] = nval; m_ph[c] = nph; m_to[c] = nto; m_ov[c] = nov;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int c;
    c = int'(a[7:4]);
    if (c >= NCH) return 32'd0;
    case (a[3:0])
      4'h0:    return {16'd0, m_div[c][7:0], 4'd0, m_ie[c], m_pen[c], m_mode[c], m_en[c]};
      4'h4:    return m_load[c];
      4'h8:    return m_val[c];
      4'hC:    return {30'd0, m_ov[c], m_to[c]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_to[c] && m_ie[c];
    return v;
  endfunction

  always @(posedge clk or negedge resetn)
    if (!resetn) model_reset();
    else         model_step(sel, we, addr, wdata);

  always @(negedge clk)
    if (mon_on) begin
      check("rdata_vs_model", rdata, model_read(addr));
      check("irq_vs_model", 32'(irq), 32'(model_irq()));
      check("irq_any_vs_model", 32'(irq_any), 32'(|model_irq()));
    end

  task automatic do_reset();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic wait_edge(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_at(input int x, input logic [7:0] a, input logic [31:0] d);
    wait_edge(x - 1);
    bus_write(a, d);
  endtask

  initial begin
    logic [31:0] d;
    int t0, t1, w, v, r;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    mon_on = 1'b1;

    // Reset values and CTRL readback masking
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 16; o += 4) begin
        bus_read(8'(c * 16 + o), d);
        check($sformatf("reset_ch%0d_off%0h", c, o), d, 32'd0);
      end
    bus_read(8'h50, d);
    check("ch5_read", d, 32'd0);
    bus_write(8'h00, 32'hFFFF_FFFF);
    bus_read(8'h00, d);
    check("ctrl_mask", d, 32'h0000_FF0F);
    bus_write(8'h50, 32'hFFFF_FFFF);
    bus_read(8'h50, d);
    check("ch5_write_ignored", d, 32'd0);
    do_reset();

    // One-shot, no prescale
    bus_write(8'h04, 32'd5);
    bus_write(8'h00, 32'h9);
    t0 = cyc;
    wait_edge(t0 + 5);
    bus_read(8'h0C, d);
    check("oneshot_status_early", d, 32'd0);
    wait_edge(t0 + 6);
    bus_read(8'h0C, d);
    check("oneshot_status", d, 32'd1);
    check("oneshot_irq", 32'(irq), 32'h1);
    bus_read(8'h00, d);
    check("oneshot_ctrl_en_clr", d, 32'h8);
    wait_edge(t0 + 9);
    bus_read(8'h08, d);
    check("oneshot_value_hold", d, 32'd0);
    do_reset();

    // Periodic with prescaler, overrun, W1C race
    bus_write(8'h04, 32'd3);
    bus_write(8'h00, 32'h030F);
    t0 = cyc;
    wait_edge(t0 + 12);
    bus_read(8'h0C, d);
    check("per_status_early", d, 32'd0);
    wait_edge(t0 + 13);
    bus_read(8'h0C, d);
    check("per_first_timeout", d, 32'd1);
    wait_edge(t0 + 24);
    bus_read(8'h0C, d);
    check("per_no_overrun_yet", d, 32'd1);
    wait_edge(t0 + 25);
    bus_read(8'h0C, d);
    check("per_overrun", d, 32'd3);
    write_at(t0 + 26, 8'h0C, 32'h3);
    bus_read(8'h0C, d);
    check("w1c_quiet", d, 32'd0);
    check("w1c_quiet_irq", 32'(irq), 32'h0);
    write_at(t0 + 37, 8'h0C, 32'h3);
    bus_read(8'h0C, d);
    check("w1c_race", d, 32'd1);
    check("w1c_race_irq", 32'(irq), 32'h1);
    do_reset();

    // Multi-channel independence
    bus_write(8'h04, 32'd10);
    bus_write(8'h34, 32'd4);
    bus_write(8'h30, 32'h9);
    t1 = cyc;
    bus_write(8'h00, 32'h3);
    wait_edge(t1 + 4);
    check("multi_irq_early", 32'(irq), 32'h0);
    wait_edge(t1 + 5);
    check("multi_irq_ch3", 32'(irq), 32'h8);
    check("multi_irq_any", 32'(irq_any), 32'h1);
    wait_edge(t1 + 12);
    bus_read(8'h0C, d);
    check("multi_ch0_status", d, 32'd1);
    check("multi_irq_masked", 32'(irq), 32'h8);
    do_reset();

    // Mid-operation control
    bus_write(8'h04, 32'd100);
    bus_write(8'h00, 32'h3);
    t0 = cyc;
    write_at(t0 + 10, 8'h08, 32'd2);
    w = cyc;
    wait_edge(w + 1);
    bus_read(8'h0C, d);
    check("force_status_early", d, 32'd0);
    wait_edge(w + 2);
    bus_read(8'h0C, d);
    check("force_timeout", d, 32'd1);
    bus_read(8'h08, d);
    check("force_reload", d, 32'd100);
    bus_write(8'h08, 32'd60);
    v = cyc;
    write_at(v + 10, 8'h00, 32'h2);
    wait_edge(v + 15);
    bus_read(8'h08, d);
    check("freeze_value", d, 32'd50);
    bus_write(8'h00, 32'h3);
    r = cyc;
    wait_edge(r + 1);
    bus_read(8'h08, d);
    check("reenable_reload", d, 32'd100);
    wait_edge(r + 5);
    resetn = 1'b0;
    bus_read(8'h08, d);
    check("async_reset_value", d, 32'd0);
    bus_read(8'h0C, d);
    check("async_reset_status", d, 32'd0);
    bus_read(8'h00, d);
    check("async_reset_ctrl", d, 32'd0);
    check("async_reset_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int ch, off;
      @(negedge clk);
      ch  = $urandom_range(0, 5);
      off = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : 4 * $urandom_range(0, 3);
      sel = ($urandom_range(0, 3) == 0);
      we  = $urandom_range(0, 1);
      addr = 8'((ch << 4) | off);
      case (off)
        0:       wdata = ($urandom & 32'hFFFF_00F0) | {22'd0, 2'($urandom_range(0, 3)), 4'd0,
                         4'($urandom_range(0, 15) | (($urandom_range(0, 2) != 0) ? 1 : 0))};
        4, 8:    wdata = $urandom_range(0, 12);
        12:      wdata = $urandom_range(0, 3);
        default: wdata = $urandom;
      endcase
      if ($urandom_range(0, 799) == 0) begin
        #2 resetn = 1'b0;
        #4 resetn = 1'b1;
      end
    end
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    @(negedge clk);
    mon_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
